dbg_trace_tx: RTL and testbench
===============================

DBG_TRACE_TX -- requirements
Module: dbg_trace_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, gives clk cycles per UART bit (27 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 4, gives the snapshot FIFO depth; it SHALL be a power of two, at least 2.
REQ-003 Port clk  in  1  single clock for all logic.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port presente  in  3  game FSM present state; also the trigger source.
REQ-006 Port puntos_bin  in  9  score, binary.
REQ-007 Port puntos_bono  in  8  bonus points.
REQ-008 Port puntos  in  8  displayed points.
REQ-009 Port force_snap  in  1  one-cycle strobe requesting an unconditional snapshot.
REQ-010 Port tx  out  1  UART serial output, idle high.
REQ-011 Port busy  out  1  high while a frame is being shifted or the FIFO is non-empty.
REQ-012 Port ovf  out  1  sticky flag: a snapshot was dropped.

Function
REQ-013 Trigger: a trigger SHALL occur in any cycle where presente differs from its registered value (prev_st) or force_snap is high; both together SHALL count as one trigger.
REQ-014 Snapshot: on a trigger in cycle N, {presente, puntos_bin, puntos_bono, puntos} sampled in cycle N SHALL be written to the FIFO at the N+1 edge.
REQ-015 FIFO full: a push SHALL be dropped, ovf SHALL be set, and FIFO contents SHALL be unchanged.
REQ-016 Full FIFO with a pop in the same cycle as a push: the pop SHALL occur first and the push SHALL be accepted; ovf SHALL NOT be set.
REQ-017 Frame: 5 bytes, sent in order.
- B0 = 0xA5
- B1 = {puntos_bin[8], 4'b0000, presente[2:0]}
- B2 = puntos_bin[7:0]
- B3 = puntos_bono
- B4 = puntos
REQ-018 Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-019 Transmit FSM states are IDLE, LOAD, START, DATA, STOP.
- IDLE -> LOAD when the FIFO is non-empty; the FIFO is popped into the frame register.
- LOAD -> START
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bits.
- STOP -> START for the next byte of the frame, or -> IDLE after B4.
REQ-020 Back-to-back frames: no extra idle bits SHALL be inserted beyond the IDLE and LOAD cycles (2 clk).
REQ-021 Bit counter and baud counter SHALL wrap to 0 at the end of each bit/byte; no counter may exceed its terminal value.
REQ-022 Input changes during a frame SHALL NOT alter that frame; only the FIFO entry is transmitted.
REQ-023 tx SHALL be driven from a flop (glitch-free).

Reset
REQ-024 While rst is high, the following SHALL be held regardless of clk:
- tx=1, busy=0, ovf=0
- FIFO empty, FSM in IDLE, all counters 0, prev_st=3'b000
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with tx=1; no partial byte resumes after release.
REQ-026 Because prev_st resets to 0, a nonzero presente after reset release SHALL produce one snapshot.

Structure
REQ-027 Package dbg_pkg SHALL hold:
- SYNC_BYTE = 8'hA5
- FRAME_BYTES = 5
- the snapshot struct type (28 bits)
- the tx state enum
REQ-028 The transmit path SHALL be a sub-module uart_tx_byte (byte in, valid/ready handshake, tx out); trigger, FIFO and frame sequencing stay in dbg_trace_tx.

Verification
REQ-029 Basic frame (CLKS_PER_BIT=4): presente 0->3 with puntos_bin=9'h105, puntos_bono=8'h22, puntos=8'h05 -> tx decodes A5 83 05 22 05, with each bit exactly 4 clk.
REQ-030 Overflow (FIFO_DEPTH=4): 6 force_snap strobes on consecutive cycles -> exactly 5 frames (1 in flight + 4 queued), ovf=1, and busy falls after the last stop bit.
REQ-031 Simultaneous events: presente change and force_snap in the same cycle -> exactly one frame.
REQ-032 Reset mid-frame: assert rst during bit 3 of B2 -> tx=1 within the same cycle, with no frame after release while presente stays 0.
REQ-033 Stability: change puntos every cycle during transmission -> the transmitted B4 equals the value sampled at the trigger cycle.
REQ-034 Timing: a single trigger -> start bit of B0 begins 3 clk after the trigger cycle, and the frame lasts 50*CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug trace UART: snapshot layout,
// frame constants and the transmit state encoding.
package dbg_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 5;

    typedef struct packed {
        logic [2:0] presente;
        logic [8:0] puntos_bin;
        logic [7:0] puntos_bono;
        logic [7:0] puntos;
    } snapshot_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    // Byte idx of the frame built from one snapshot; idx 0 is the sync marker.
    function automatic logic [7:0] frame_byte(input snapshot_t snap, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = {snap.puntos_bin[8], 4'b0000, snap.presente};
            3'd2:    b = snap.puntos_bin[7:0];
            3'd3:    b = snap.puntos_bono;
            3'd4:    b = snap.puntos;
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready byte handshake. Bytes offered in the
// last stop-bit cycle chain straight into the next start bit with no idle gap.
module uart_tx_byte
    import dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       tx,
    output logic       active
);

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_t     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          baud_done_s;

    assign baud_done_s = (baud_q == BAUD_LAST);
    assign byte_ready  = (state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_done_s);
    assign active      = (state_q != ST_IDLE);
    assign tx          = tx_q;

    // Next-state, counter and line-level logic; tx_d is the level for the next cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = 3'd0;
                if (byte_valid) begin
                    shift_d = byte_data;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = ST_START;
            end
            ST_START: begin
                if (baud_done_s) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (baud_done_s) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (baud_done_s) begin
                    baud_d = '0;
                    if (byte_valid) begin
                        shift_d = byte_data;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                baud_d  = '0;
                bit_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/dbg_trace_tx.sv
// Debug trace transmitter: snapshots game state on a state change or forced
// strobe, queues snapshots in a small FIFO and streams each as a 5-byte UART frame.
module dbg_trace_tx
    import dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] presente,
    input  logic [8:0] puntos_bin,
    input  logic [7:0] puntos_bono,
    input  logic [7:0] puntos,
    input  logic       force_snap,
    output logic       tx,
    output logic       busy,
    output logic       ovf
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam int         CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    logic [2:0]    prev_st_q, prev_st_d;
    snapshot_t     mem_q [FIFO_DEPTH];
    snapshot_t     mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    snapshot_t     frame_q, frame_d;
    logic [2:0]    idx_q, idx_d;
    logic          ovf_q, ovf_d;

    snapshot_t snap_s, head_s;
    logic      trigger_s, empty_s, full_s, accept_s, pop_s, hs_s;
    logic      byte_valid_s, byte_ready_s, tx_active_s;
    logic [7:0] byte_data_s;

    assign snap_s    = {presente, puntos_bin, puntos_bono, puntos};
    assign trigger_s = (presente != prev_st_q) || force_snap;
    assign head_s    = mem_q[rd_ptr_q];
    assign empty_s   = (cnt_q == '0);
    assign full_s    = (cnt_q == FULL_CNT);

    // idx_q == 0 means no frame is in progress: the next byte is B0 of the FIFO head,
    // offered only once the serializer has returned to idle.
    assign byte_valid_s = (idx_q != 3'd0) || (!empty_s && !tx_active_s);
    assign byte_data_s  = frame_byte((idx_q == 3'd0) ? head_s : frame_q, idx_q);
    assign hs_s         = byte_valid_s && byte_ready_s;
    assign pop_s        = hs_s && (idx_q == 3'd0);
    assign accept_s     = trigger_s && (!full_s || pop_s);

    assign busy = tx_active_s || !empty_s;
    assign ovf  = ovf_q;

    // FIFO, overflow flag and frame sequencing; a pop frees its slot for a same-cycle push.
    always_comb begin
        prev_st_d = presente;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        if (accept_s) begin
            mem_d[wr_ptr_q] = snap_s;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else if (trigger_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            frame_d  = head_s;
            idx_d    = 3'd1;
        end else if (hs_s) begin
            idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
        end else begin
            idx_d = idx_q;
        end
        case ({accept_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Trigger history, FIFO and frame registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_st_q <= 3'b000;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            frame_q  <= '0;
            idx_q    <= 3'd0;
            ovf_q    <= 1'b0;
        end else begin
            prev_st_q <= prev_st_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .byte_data (byte_data_s),
        .byte_valid(byte_valid_s),
        .byte_ready(byte_ready_s),
        .tx        (tx),
        .active    (tx_active_s)
    );

endmodule

// File: tb/tb_dbg_trace_tx.sv
// Scoreboard bench for dbg_trace_tx: stimulus queues expected frame bytes,
// a UART monitor decodes tx and checks each byte against the queue.
module tb_dbg_trace_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] presente;
    logic [8:0] puntos_bin;
    logic [7:0] puntos_bono;
    logic [7:0] puntos;
    logic       force_snap;
    logic       tx;
    logic       busy;
    logic       ovf;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    dbg_trace_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .presente   (presente),
        .puntos_bin (puntos_bin),
        .puntos_bono(puntos_bono),
        .puntos     (puntos),
        .force_snap (force_snap),
        .tx         (tx),
        .busy       (busy),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        exp_q.push_back(8'hA5);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // UART monitor: 4 samples per bit, all equal within a bit, start 0 and stop 1.
    initial begin : monitor
        logic       samp [40];
        logic       aborted;
        logic       frame_ok;
        logic [7:0] got;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                aborted = 1'b0;
                samp[0] = tx;
                for (int k = 1; k < 40; k++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) aborted = 1'b1;
                    samp[k] = tx;
                end
                if (!aborted) begin
                    frame_ok = 1'b1;
                    for (int j = 0; j < 10; j++)
                        for (int m = 1; m < 4; m++)
                            if (samp[j*4+m] !== samp[j*4]) frame_ok = 1'b0;
                    if (samp[36] !== 1'b1) frame_ok = 1'b0;
                    for (int i = 0; i < 8; i++) got[i] = samp[(i+1)*4];
                    check("uart_framing", 32'(frame_ok), 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got %02h expected no byte", got);
                    end else begin
                        exp = exp_q.pop_front();
                        check("uart_byte", 32'(got), 32'(exp));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; presente = 3'd0; puntos_bin = 9'h000; puntos_bono = 8'h00;
        puntos = 8'h00; force_snap = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Basic frame and latency: start bit 3 clk after trigger, frame 50*CPB long.
        puntos_bin = 9'h105; puntos_bono = 8'h22; puntos = 8'h05; presente = 3'd3;
        push_frame(8'h83, 8'h05, 8'h22, 8'h05);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_start_tx", 32'(tx), 32'd1);
        check("busy_loading", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("start_bit_latency", 32'(tx), 32'd0);
        repeat (199) @(posedge clk);
        @(negedge clk);
        check("busy_last_stop", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("busy_after_frame", 32'(busy), 32'd0);
        check("drained_basic", 32'(exp_q.size()), 32'd0);

        // Inputs changing during the frame must not leak into it.
        tick();
        presente = 3'd1; puntos_bin = 9'h0FF; puntos_bono = 8'h7E; puntos = 8'h5A;
        push_frame(8'h01, 8'hFF, 8'h7E, 8'h5A);
        tick();
        for (int c = 0; c < 220; c++) begin
            puntos      = 8'($urandom_range(0, 255));
            puntos_bono = 8'($urandom_range(0, 255));
            tick();
        end
        wait_idle(60, "idle_stability");
        check("drained_stability", 32'(exp_q.size()), 32'd0);

        // State change and force_snap together give one frame.
        tick();
        presente = 3'd6; force_snap = 1'b1; puntos_bin = 9'h1AA; puntos_bono = 8'h00; puntos = 8'hFF;
        push_frame(8'h86, 8'hAA, 8'h00, 8'hFF);
        tick();
        force_snap = 1'b0;
        wait_idle(300, "idle_simultaneous");
        repeat (20) tick();
        check("no_extra_frame", 32'(busy), 32'd0);
        check("drained_simultaneous", 32'(exp_q.size()), 32'd0);
        check("ovf_before_burst", 32'(ovf), 32'd0);

        // Six strobes: one in flight, four queued, last dropped.
        for (int i = 0; i < 6; i++) begin
            tick();
            force_snap  = 1'b1;
            puntos_bin  = 9'h010 + 9'(i);
            puntos_bono = 8'h30 + 8'(i);
            puntos      = 8'h40 + 8'(i);
            if (i < 5) push_frame(8'h06, 8'h10 + 8'(i), 8'h30 + 8'(i), 8'h40 + 8'(i));
        end
        tick();
        force_snap = 1'b0;
        @(negedge clk);
        check("ovf_set", 32'(ovf), 32'd1);
        wait_idle(5 * 210, "idle_after_burst");
        check("tx_idle_after_burst", 32'(tx), 32'd1);
        check("ovf_sticky", 32'(ovf), 32'd1);
        check("drained_burst", 32'(exp_q.size()), 32'd0);

        // Reset during bit 3 of B2 (0xC3, bit 3 = 0).
        tick();
        presente = 3'd2; puntos_bin = 9'h0C3; puntos_bono = 8'h44; puntos = 8'h66;
        push_frame(8'h02, 8'hC3, 8'h44, 8'h66);
        repeat (3) @(posedge clk);
        repeat (97) @(posedge clk);
        #1;
        check("pre_reset_data_bit", 32'(tx), 32'd0);
        #1;
        rst = 1'b1;
        presente = 3'd0;
        #1;
        check("reset_abort_tx", 32'(tx), 32'd1);
        exp_q.delete();
        repeat (3) tick();
        check("reset_busy_mid", 32'(busy), 32'd0);
        check("reset_clears_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        repeat (300) tick();
        check("no_frame_after_reset", 32'(busy), 32'd0);
        check("tx_idle_after_reset", 32'(tx), 32'd1);

        // Nonzero presente across reset release gives one snapshot.
        rst = 1'b1;
        presente = 3'd5; puntos_bin = 9'h123; puntos_bono = 8'h11; puntos = 8'h99;
        repeat (2) tick();
        rst = 1'b0;
        push_frame(8'h85, 8'h23, 8'h11, 8'h99);
        tick();
        wait_idle(260, "idle_after_release");
        repeat (20) tick();
        check("single_frame_after_release", 32'(busy), 32'd0);
        check("drained_release", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
